dbus_tx_arbiter: RTL

Packet-atomic arbiter that shares the single byte-wide transmit input of the `dbus` link engine between two byte-stream requesters. Typical requesters are the UART-RX FIFO drain path and a local reply/ACK generator. It sits between the requesters and `dbus` (`i_data`/`i_enable`/`o_busy`) in the bridge, on the bus clock. Once granted, a requester keeps the bus until its last byte is sent, so packets are never interleaved. A watchdog aborts a stalled packet.

---
 rtl/dbus_tx_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dbus_tx_arbiter.sv
// dbus_tx_arbiter: packet-atomic arbiter feeding the dbus transmit input from
// two byte-stream requesters. The owner keeps the bus until its last byte has
// completed, and a watchdog aborts a stalled owner or a hung dbus handshake.
module dbus_tx_arbiter #(
  parameter int c_TIMEOUT  = 4096,
  parameter int c_CNTWIDTH = $clog2(c_TIMEOUT + 1)
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_last,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_last,
  output logic       o_req0_ready,
  output logic       o_req1_ready,
  output logic [7:0] o_data,
  output logic       o_enable,
  input  logic       i_busy,
  output logic [1:0] o_grant,
  output logic       o_abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_data;
  logic                  r_last;
  logic [1:0]            r_grant;
  logic                  r_rr;        // 1: req1 wins the next tie
  logic [c_CNTWIDTH-1:0] r_count;
  logic                  r_ready0;
  logic                  r_ready1;
  logic                  r_abort;

  logic                  w_capture;
  logic                  w_sel;       // 1: capture from req1
  logic                  w_done;
  logic                  w_abort;
  logic                  w_timeout;
  logic                  w_owner_valid;
  logic                  w_counting;

  // Next-state, capture selection, packet end and watchdog abort decisions
  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_sel         = 1'b0;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    w_timeout     = (r_count == c_CNTWIDTH'(c_TIMEOUT - 1));
    w_owner_valid = r_grant[1] ? i_req1_valid : i_req0_valid;
    w_counting    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          w_capture    = 1'b1;
          w_sel        = i_req1_valid && (!i_req0_valid || r_rr);
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        w_counting = 1'b1;
        if (i_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        w_counting = 1'b1;
        if (!i_busy) begin
          if (r_last) begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_NEXT;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      S_NEXT: begin
        w_counting = 1'b1;
        if (w_owner_valid) begin
          w_capture    = 1'b1;
          w_sel        = r_grant[1];
          w_state_next = S_ISSUE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A legitimate transition takes priority, so abort only ever fires while
    // the state would otherwise stay put.
    if (w_abort) begin
      w_state_next = S_IDLE;
    end
  end

  // State register and watchdog counter; the counter restarts on every state change
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_count <= '0;
      end else if (w_counting) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Byte capture, ownership, round-robin pointer and one-cycle pulses
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data   <= '0;
      r_last   <= 1'b0;
      r_grant  <= '0;
      r_rr     <= 1'b0;
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_ready0 <= w_capture && !w_sel;
      r_ready1 <= w_capture && w_sel;
      r_abort  <= w_abort;
      if (w_capture) begin
        r_data  <= w_sel ? i_req1_data : i_req0_data;
        r_last  <= w_sel ? i_req1_last : i_req0_last;
        r_grant <= w_sel ? 2'b10 : 2'b01;
      end else if (w_done || w_abort) begin
        r_grant <= '0;
        r_rr    <= r_grant[0];
      end
    end
  end

  assign o_data       = r_data;
  assign o_enable     = (r_state == S_ISSUE) && (r_grant != 2'b00);
  assign o_grant      = r_grant;
  assign o_abort      = r_abort;
  assign o_req0_ready = r_ready0;
  assign o_req1_ready = r_ready1;

endmodule
